// File: rtl/adc_seq_pkg.sv
// Shared types for the ADC scan sequencer: FSM state encoding and channel-index width helper.
package adc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        START,
        WAIT,
        OUT
    } state_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_ch_pick.sv
// Combinational channel picker: next enabled index above cur, or the lowest enabled index when first=1.
module adc_ch_pick import adc_seq_pkg::*; #(
    parameter int N_CH = 4,
    parameter int CH_W = ch_width(N_CH)
) (
    input  logic [N_CH-1:0] mask,
    input  logic [CH_W-1:0] cur,
    input  logic            first,
    output logic [CH_W-1:0] nxt,
    output logic            found
);

    // Scan downward so the lowest qualifying index is the one left standing.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[i] && (first || (CH_W'(i) > cur))) begin
                nxt   = CH_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_scan_seq.sv
// Scan sequencer in front of a SAR ADC: steps the analog mux over enabled channels,
// settles, triggers conversions, optionally averages, and emits one tagged result per channel.
module adc_scan_seq import adc_seq_pkg::*; #(
    parameter int ADC_WIDTH  = 8,
    parameter int N_CH       = 4,
    parameter int SETTLE_CYC = 2,
    parameter int AVG_LOG2   = 0,
    parameter int TIMEOUT    = 4 * ADC_WIDTH,
    parameter int CH_W       = ch_width(N_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trig,
    input  logic                 en,
    input  logic [N_CH-1:0]      ch_mask,
    output logic                 adc_start,
    input  logic                 adc_den,
    input  logic [ADC_WIDTH-1:0] adc_dout,
    output logic [CH_W-1:0]      mux_sel,
    output logic                 busy,
    output logic                 res_valid,
    output logic [CH_W-1:0]      res_ch,
    output logic [ADC_WIDTH-1:0] res_data,
    output logic                 scan_done,
    output logic                 err_timeout
);

    localparam int AW = ADC_WIDTH + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int NS = 1 << AVG_LOG2;

    state_t          state, state_n;
    logic [N_CH-1:0] mask_q, pick_mask;
    logic [AW-1:0]   acc, acc_sum;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   settle;
    logic [TW-1:0]   timer;
    logic [CH_W-1:0] pick_idx;
    logic            pick_found, expire, last_sample;

    // In IDLE the live mask picks the first channel; afterwards only the latched copy matters.
    assign pick_mask   = (state == IDLE) ? ch_mask : mask_q;
    assign acc_sum     = acc + AW'(adc_dout);
    assign last_sample = (cnt == CW'(NS - 1));

    adc_ch_pick #(.N_CH(N_CH), .CH_W(CH_W)) u_pick (
        .mask  (pick_mask),
        .cur   (mux_sel),
        .first (state == IDLE),
        .nxt   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_n = state;
        expire  = 1'b0;
        case (state)
            IDLE:   if ((trig || en) && pick_found) state_n = SELECT;
            SELECT: if (settle == SW'(SETTLE_CYC - 1)) state_n = START;
            START:  state_n = WAIT;
            WAIT: begin
                if (adc_den) begin
                    state_n = last_sample ? OUT : START;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    state_n = OUT;
                    expire  = 1'b1;
                end
            end
            OUT:     state_n = pick_found ? SELECT : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mask_q      <= '0;
            acc         <= '0;
            cnt         <= '0;
            settle      <= '0;
            timer       <= '0;
            mux_sel     <= '0;
            busy        <= 1'b0;
            adc_start   <= 1'b0;
            res_valid   <= 1'b0;
            res_ch      <= '0;
            res_data    <= '0;
            scan_done   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state     <= state_n;
            busy      <= (state_n != IDLE);
            adc_start <= (state_n == START);
            res_valid <= 1'b0;
            scan_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (state_n == SELECT) begin
                        mask_q  <= ch_mask;
                        mux_sel <= pick_idx;
                        settle  <= '0;
                        acc     <= '0;
                        cnt     <= '0;
                    end
                end
                SELECT: settle <= settle + 1'b1;
                START:  timer  <= '0;
                WAIT: begin
                    timer <= timer + 1'b1;
                    if (adc_den) begin
                        acc <= acc_sum;
                        cnt <= cnt + 1'b1;
                        if (last_sample) begin
                            res_valid <= 1'b1;
                            res_ch    <= mux_sel;
                            res_data  <= ADC_WIDTH'(acc_sum >> AVG_LOG2);
                            scan_done <= !pick_found;
                        end
                    end else if (expire) begin
                        err_timeout <= 1'b1;
                        scan_done   <= !pick_found;
                    end
                end
                OUT: begin
                    if (pick_found) begin
                        mux_sel <= pick_idx;
                        settle  <= '0;
                        acc     <= '0;
                        cnt     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_scan_seq.sv
// Directed bench for adc_scan_seq with behavioural ADC responders and result scoreboards.
module tb_adc_scan_seq;

    localparam int SETTLE = 2;
    localparam int TMO    = 32;
    localparam int LAT    = 3;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] data;
    } exp_t;

    logic       clk, rst;
    logic       trig, en, adc_den, adc_start, busy, res_valid, scan_done, err_timeout;
    logic [3:0] ch_mask;
    logic [7:0] adc_dout, res_data;
    logic [1:0] mux_sel, res_ch;

    logic       trig_b, en_b, den_b, start_b, busy_b, rv_b, done_b, err_b;
    logic [3:0] mask_b;
    logic [7:0] dout_b, data_b;
    logic [1:0] sel_b, rch_b;

    int checks = 0, errors = 0, cyc = 0;
    exp_t qa[$], qb[$];
    exp_t ea, eb;
    logic [7:0] lvl [4];
    int   cd_a = 0, cd_b = 0, kill_ch = -1, sb = 0, starts_b = 0, nden_b = 0;
    logic den_seen, den_seen_b;

    adc_scan_seq #(.ADC_WIDTH(8), .N_CH(4), .SETTLE_CYC(SETTLE), .AVG_LOG2(0), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .trig(trig), .en(en), .ch_mask(ch_mask),
        .adc_start(adc_start), .adc_den(adc_den), .adc_dout(adc_dout),
        .mux_sel(mux_sel), .busy(busy), .res_valid(res_valid), .res_ch(res_ch),
        .res_data(res_data), .scan_done(scan_done), .err_timeout(err_timeout)
    );

    adc_scan_seq #(.ADC_WIDTH(8), .N_CH(4), .SETTLE_CYC(SETTLE), .AVG_LOG2(2), .TIMEOUT(TMO)) dut_avg (
        .clk(clk), .rst(rst), .trig(trig_b), .en(en_b), .ch_mask(mask_b),
        .adc_start(start_b), .adc_den(den_b), .adc_dout(dout_b),
        .mux_sel(sel_b), .busy(busy_b), .res_valid(rv_b), .res_ch(rch_b),
        .res_data(data_b), .scan_done(done_b), .err_timeout(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) den_seen <= adc_den;
    always @(posedge clk) den_seen_b <= den_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!scan_done && n < budget);
        chk(tag, 32'(scan_done), 1);
    endtask

    // ADC responder for the main DUT: den LAT cycles after start, level chosen by mux_sel.
    always @(negedge clk) begin
        adc_den = 1'b0;
        if (cd_a > 0) begin
            cd_a--;
            if (cd_a == 0 && int'(mux_sel) != kill_ch) begin
                adc_den  = 1'b1;
                adc_dout = lvl[mux_sel];
            end
        end
        if (adc_start) cd_a = LAT;
    end

    // ADC responder for the averaging DUT: returns 10, 11, 12, 13 ...
    always @(negedge clk) begin
        den_b = 1'b0;
        if (cd_b > 0) begin
            cd_b--;
            if (cd_b == 0) begin
                den_b  = 1'b1;
                dout_b = 8'(10 + sb);
                sb++;
            end
        end
        if (start_b) cd_b = LAT;
    end

    always @(negedge clk) begin
        if (res_valid) begin
            chk("rv_latency", 32'(den_seen), 1);
            if (qa.size() == 0) chk("spurious_rv", 32'(res_valid), 0);
            else begin
                ea = qa.pop_front();
                chk("res_ch", 32'(res_ch), 32'(ea.ch));
                chk("res_data", 32'(res_data), 32'(ea.data));
            end
        end
    end

    always @(negedge clk) begin
        if (start_b) starts_b++;
        if (den_seen_b) begin
            nden_b++;
            if (nden_b < 4) chk("avg_restart", 32'(start_b), 1);
            else chk("avg_rv_timing", 32'(rv_b), 1);
        end
        if (rv_b) begin
            if (qb.size() == 0) chk("spurious_rv_avg", 32'(rv_b), 0);
            else begin
                eb = qb.pop_front();
                chk("avg_ch", 32'(rch_b), 32'(eb.ch));
                chk("avg_data", 32'(data_b), 32'(eb.data));
            end
        end
    end

    initial begin
        int n, t1, t2, t3, rvn;
        rst = 1'b1; trig = 1'b0; en = 1'b0; ch_mask = '0; adc_dout = '0; adc_den = 1'b0;
        trig_b = 1'b0; en_b = 1'b0; mask_b = '0; dout_b = '0; den_b = 1'b0;
        lvl = '{8'h10, 8'h80, 8'hC0, 8'hFF};
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rv", 32'(res_valid), 0);
        chk("rst_start", 32'(adc_start), 0);
        chk("rst_err", 32'(err_timeout), 0);
        rst = 1'b0;

        // empty mask: trigger is ignored
        trig = 1'b1; @(negedge clk); trig = 1'b0;
        chk("mask0_idle", 32'(busy), 0);

        // full mask, single scan
        for (int i = 0; i < 4; i++) qa.push_back('{ch: 2'(i), data: lvl[i]});
        ch_mask = 4'hF; trig = 1'b1; @(negedge clk); trig = 1'b0;
        wait_done("full_done", 300);
        chk("full_last_ch", 32'(res_ch), 3);
        chk("full_last_rv", 32'(res_valid), 1);
        @(negedge clk);
        chk("full_busy_low", 32'(busy), 0);
        chk("full_q_empty", qa.size(), 0);

        // sparse mask, start latency, trig while busy
        lvl = '{8'h33, 8'h44, 8'h55, 8'h66};
        qa.push_back('{ch: 2'd0, data: 8'h33});
        qa.push_back('{ch: 2'd2, data: 8'h55});
        ch_mask = 4'b0101; trig = 1'b1; @(negedge clk); trig = 1'b0;
        n = 1;
        chk("sparse_busy", 32'(busy), 1);
        chk("sparse_sel0", 32'(mux_sel), 0);
        while (!adc_start && n < 20) begin @(negedge clk); n++; end
        chk("sparse_start_lat", n, SETTLE + 1);
        trig = 1'b1; @(negedge clk); trig = 1'b0;
        wait_done("sparse_done", 300);
        chk("sparse_last_ch", 32'(res_ch), 2);
        repeat (20) @(negedge clk);
        chk("sparse_no_rescan", 32'(busy), 0);
        chk("sparse_q_empty", qa.size(), 0);

        // timeout on ch1
        lvl = '{8'h21, 8'h22, 8'h23, 8'h24};
        kill_ch = 1;
        qa.push_back('{ch: 2'd0, data: 8'h21});
        ch_mask = 4'b0011; trig = 1'b1; @(negedge clk); trig = 1'b0;
        n = 0;
        while (!(adc_start && mux_sel == 2'd1) && n < 200) begin @(negedge clk); n++; end
        chk("tmo_ch1_start", 32'(adc_start), 1);
        n = 0;
        while (!err_timeout && n < 200) begin @(negedge clk); n++; end
        chk("tmo_cycles", n, TMO + 1);
        chk("tmo_no_rv", 32'(res_valid), 0);
        n = 0;
        while (busy && n < 50) begin @(negedge clk); n++; end
        chk("tmo_scan_end", 32'(busy), 0);
        repeat (5) @(negedge clk);
        chk("tmo_sticky", 32'(err_timeout), 1);
        chk("tmo_q_empty", qa.size(), 0);
        kill_ch = -1;

        // averaging on the second instance: (10+11+12+13)/4 = 11
        qb.push_back('{ch: 2'd0, data: 8'd11});
        mask_b = 4'b0001; trig_b = 1'b1; @(negedge clk); trig_b = 1'b0;
        n = 0;
        while (!done_b && n < 300) begin @(negedge clk); n++; end
        chk("avg_done", 32'(done_b), 1);
        @(negedge clk);
        chk("avg_starts", starts_b, 4);
        chk("avg_q_empty", qb.size(), 0);

        // continuous scan
        lvl = '{8'h11, 8'h7A, 8'h5C, 8'h99};
        for (int i = 0; i < 3; i++) qa.push_back('{ch: 2'd1, data: 8'h7A});
        ch_mask = 4'b0010; en = 1'b1;
        wait_done("cont_d1", 300);
        t1 = cyc;
        @(negedge clk);
        chk("cont_gap_idle", 32'(busy), 0);
        @(negedge clk);
        chk("cont_gap_resume", 32'(busy), 1);
        wait_done("cont_d2", 300);
        t2 = cyc;
        repeat (3) @(negedge clk);
        ch_mask = 4'b0100; trig = 1'b1; @(negedge clk); trig = 1'b0;
        qa.push_back('{ch: 2'd2, data: 8'h5C});
        wait_done("cont_d3", 300);
        t3 = cyc;
        chk("cont_period", t3 - t2, t2 - t1);
        chk("cont_mask_hold", 32'(res_ch), 1);
        repeat (2) @(negedge clk);
        en = 1'b0;
        wait_done("cont_d4", 300);
        chk("cont_new_mask", 32'(res_ch), 2);
        repeat (10) @(negedge clk);
        chk("cont_stopped", 32'(busy), 0);
        chk("cont_q_empty", qa.size(), 0);

        // reset during WAIT; the late den must be ignored
        ch_mask = 4'b1000; trig = 1'b1; @(negedge clk); trig = 1'b0;
        n = 0;
        while (!adc_start && n < 20) begin @(negedge clk); n++; end
        chk("rstw_started", 32'(adc_start), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstw_busy", 32'(busy), 0);
        chk("rstw_sel", 32'(mux_sel), 0);
        chk("rstw_start", 32'(adc_start), 0);
        chk("rstw_rv", 32'(res_valid), 0);
        chk("rstw_ch", 32'(res_ch), 0);
        chk("rstw_data", 32'(res_data), 0);
        chk("rstw_done", 32'(scan_done), 0);
        chk("rstw_err", 32'(err_timeout), 0);
        rvn = 0;
        repeat (10) begin @(negedge clk); if (res_valid) rvn++; end
        chk("rstw_no_late_rv", rvn, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
